// File: rtl/gal_olmc_bank.sv
// rtl/gal_olmc_bank.sv - bank of N GAL output logic macrocells with serial fuse loader
//
// Purpose: cycle-accurate model of N OLMC cells fed by the AND array. Each cell
// is configured as registered/combinational and inverted/non-inverted through a
// 2N-bit serial fuse chain (cfg[2i] = registered, cfg[2i+1] = inverted).
//
// Ports:
//   C         clock, all registers sample on posedge
//   RN        asynchronous active-low reset
//   SP        synchronous preset of all cell registers (GAL_OLMC_SYNC_PRESET_EN only)
//   CFG_EN    config shift enable
//   CFG_D     serial config data, first bit lands in cfg[0]
//   A[N]      sum-term input per cell
//   E[N]      output-enable product term per cell
//   Y[N]      pad value
//   YE[N]     pad drive enable (0 = pad undriven)
//   FB[N]     feedback to the AND array
//   CFG_DONE  valid configuration active
//   CFG_ERR   last load had the wrong length
//
// Optional feature macro: GAL_OLMC_SYNC_PRESET_EN
module gal_olmc_bank #(
  parameter int N = 8
) (
  input  logic         C,
  input  logic         RN,
`ifdef GAL_OLMC_SYNC_PRESET_EN
  input  logic         SP,
`endif
  input  logic         CFG_EN,
  input  logic         CFG_D,
  input  logic [N-1:0] A,
  input  logic [N-1:0] E,
  output logic [N-1:0] Y,
  output logic [N-1:0] YE,
  output logic [N-1:0] FB,
  output logic         CFG_DONE,
  output logic         CFG_ERR
);

  localparam int CW = $clog2(2 * N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(2 * N);
  localparam logic [CW-1:0] CNT_SAT  = CW'(2 * N + 1);

  typedef enum logic [1:0] {ST_UNCFG, ST_SHIFT, ST_RUN, ST_ERR} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [2*N-1:0]   sr_q;
  logic [2*N-1:0]   cfg_q;
  logic [N-1:0]     q;
  logic             done_q;
  logic             err_q;

  // State register
  always_ff @(posedge C or negedge RN) begin
    if (!RN) state_q <= ST_UNCFG;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SHIFT: if (!CFG_EN) state_d = (cnt_q == CNT_FULL) ? ST_RUN : ST_ERR;
      default:  if (CFG_EN)  state_d = ST_SHIFT;
    endcase
  end

  // Fuse chain, bit counter and active configuration. The active config and
  // CFG_DONE are only touched on the leaving-SHIFT edge, so a reload started
  // from RUN keeps the old configuration live until the commit edge.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      cfg_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (CFG_EN) begin
      sr_q <= {CFG_D, sr_q[2*N-1:1]};
      if (state_q != ST_SHIFT) begin
        cnt_q <= CW'(1);
        err_q <= 1'b0;
      end else if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (state_q == ST_SHIFT) begin
      cnt_q <= '0;
      if (cnt_q == CNT_FULL) begin
        cfg_q  <= sr_q;
        done_q <= 1'b1;
      end else begin
        cfg_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b1;
      end
    end
  end

  // Cell registers capture in every state, so a cell switched to registered
  // immediately exposes whatever it last sampled.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      q <= '0;
    end else begin
`ifdef GAL_OLMC_SYNC_PRESET_EN
      q <= SP ? '1 : A;
`else
      q <= A;
`endif
    end
  end

  // Output logic: only a committed configuration drives the pads.
  always_comb begin
    Y  = '0;
    YE = '0;
    FB = '0;
    for (int i = 0; i < N; i++) begin
      if (done_q) begin
        if (cfg_q[2*i]) begin
          Y[i]  = q[i] ^ cfg_q[2*i+1];
          FB[i] = q[i];
        end else begin
          Y[i]  = A[i] ^ cfg_q[2*i+1];
          FB[i] = A[i] ^ cfg_q[2*i+1];
        end
        YE[i] = E[i];
      end
    end
  end

  assign CFG_DONE = done_q;
  assign CFG_ERR  = err_q;

endmodule

// File: tb/tb_gal_olmc_bank.sv
// tb/tb_gal_olmc_bank.sv - scoreboard testbench for gal_olmc_bank
module tb_gal_olmc_bank;

  localparam int N = 8;

  logic         C;
  logic         RN;
`ifdef GAL_OLMC_SYNC_PRESET_EN
  logic         SP;
`endif
  logic         CFG_EN;
  logic         CFG_D;
  logic [N-1:0] A;
  logic [N-1:0] E;
  logic [N-1:0] Y;
  logic [N-1:0] YE;
  logic [N-1:0] FB;
  logic         CFG_DONE;
  logic         CFG_ERR;

  gal_olmc_bank #(.N(N)) dut (
    .C        (C),
    .RN       (RN),
`ifdef GAL_OLMC_SYNC_PRESET_EN
    .SP       (SP),
`endif
    .CFG_EN   (CFG_EN),
    .CFG_D    (CFG_D),
    .A        (A),
    .E        (E),
    .Y        (Y),
    .YE       (YE),
    .FB       (FB),
    .CFG_DONE (CFG_DONE),
    .CFG_ERR  (CFG_ERR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  typedef logic [3*N+1:0] exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total_cnt = 0;
  int    pass_cnt  = 0;
  exp_t  mon_exp;
  exp_t  mon_act;
  string mon_name;

  // Monitor: all expectations queued during a cycle are compared on the
  // following falling edge, away from the sampling edge.
  always @(negedge C) begin
    while (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {Y, YE, FB, CFG_DONE, CFG_ERR};
      total_cnt++;
      if (mon_act === mon_exp) pass_cnt++;
      else $display("FAIL %s: got Y=%h YE=%h FB=%h DONE=%b ERR=%b, expected Y=%h YE=%h FB=%h DONE=%b ERR=%b",
                    mon_name, mon_act[25:18], mon_act[17:10], mon_act[9:2], mon_act[1], mon_act[0],
                    mon_exp[25:18], mon_exp[17:10], mon_exp[9:2], mon_exp[1], mon_exp[0]);
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] y, input logic [N-1:0] ye,
                     input logic [N-1:0] fb, input logic dn, input logic er);
    exp_q.push_back({y, ye, fb, dn, er});
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic load(input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      CFG_EN = 1'b1;
      CFG_D  = bits[k];
      tick();
    end
    CFG_EN = 1'b0;
    CFG_D  = 1'b0;
    tick();
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    total_cnt++;
    finish_run();
  end

  logic [N-1:0] qm;

  initial begin
    RN = 1'b0; CFG_EN = 1'b0; CFG_D = 1'b0; A = '0; E = '0;
`ifdef GAL_OLMC_SYNC_PRESET_EN
    SP = 1'b0;
`endif
    tick();
    chk("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    RN = 1'b1;

    // Registered, non-inverted
    load(32'h5555, 16);
    A = 8'hA5; E = 8'hFF;
    chk("reg_before_edge", 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
    tick();
    chk("reg_after_edge", 8'hA5, 8'hFF, 8'hA5, 1'b1, 1'b0);

    // Combinational, inverted: no clock edge after the input change
    load(32'hAAAA, 16);
    A = 8'h3C; E = 8'h0F;
    #1;
    chk("comb_inv", 8'hC3, 8'h0F, 8'hC3, 1'b1, 1'b0);
    tick();

    // Wrong lengths then a good load
    load(32'h5555, 15);
    chk("err_15", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    load(32'h15555, 17);
    chk("err_17", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    load(32'hAAAA, 16);
    chk("recover_16", 8'hC3, 8'h0F, 8'hC3, 1'b1, 1'b0);
    tick();

    // Reset mid-shift
    for (int k = 0; k < 7; k++) begin
      CFG_EN = 1'b1; CFG_D = 1'b1;
      tick();
    end
    RN = 1'b0; CFG_EN = 1'b0;
    #1;
    chk("rst_mid_shift", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    RN = 1'b1;
    load(32'h5555, 16);
    A = 8'hA5; E = 8'hFF;
    tick();
    chk("after_rst_load", 8'hA5, 8'hFF, 8'hA5, 1'b1, 1'b0);

    // Reconfigure from RUN with 16'hFFFF while A toggles
    qm = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      CFG_EN = 1'b1; CFG_D = 1'b1;
      A = 8'((k * 29) ^ 8'h5A);
      chk("reconf_shift", qm, 8'hFF, qm, 1'b1, 1'b0);
      @(posedge C);
      qm = A;
      #1;
    end
    CFG_EN = 1'b0; CFG_D = 1'b0;
    A = 8'hC6;
    chk("reconf_last_old", qm, 8'hFF, qm, 1'b1, 1'b0);
    @(posedge C);
    qm = A;
    #1;
    chk("reconf_commit", 8'h39, 8'hFF, 8'hC6, 1'b1, 1'b0);
    A = 8'h39;
    tick();
    chk("reconf_next", 8'hC6, 8'hFF, 8'h39, 1'b1, 1'b0);

`ifdef GAL_OLMC_SYNC_PRESET_EN
    load(32'h5557, 16);
    SP = 1'b1; A = 8'h00; E = 8'hFF;
    tick();
    chk("preset", 8'hFE, 8'hFF, 8'hFF, 1'b1, 1'b0);
    RN = 1'b0;
    #1;
    chk("preset_rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    SP = 1'b0;
    RN = 1'b1;
`endif

    tick();
    @(negedge C);
    #1;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    finish_run();
  end

endmodule

// File: doc/gal_olmc_bank.md
Name: gal_olmc_bank

Overview:
- Cycle-accurate behavioural model of a bank of N GAL output logic macrocells. It consumes the sum terms and output-enable product terms that the AND array drives into the OLMC cells after techmapping.
- Each cell is configured as registered or combinational and as inverted or non-inverted. Configuration is loaded through a serial fuse shift chain with a load state machine.
- Used as the simulation target for mapped netlists and as the golden model for post-fit equivalence runs.

Parameters:
- N, 8, number of macrocells in the bank (1..16).

Ports:
- C  in  1  clock; all registers sample on posedge C.
- RN  in  1  reset, asynchronous, active-low.
- CFG_EN  in  1  config shift enable.
- CFG_D  in  1  serial config data.
- A  in  N  sum-term input per cell.
- E  in  N  output-enable product term per cell.
- Y  out  N  pad value.
- YE  out  N  pad drive enable. Bank is modelled without tri-state; YE=0 means the pad is undriven.
- FB  out  N  feedback to the AND array.
- CFG_DONE  out  1  valid configuration active.
- CFG_ERR  out  1  last load had the wrong length.

Behaviour:
- Config word is 2N bits. cfg[2i] = REGISTERED of cell i; cfg[2i+1] = INVERTED of cell i.
- Bit k received (k=0 first) lands in cfg[k].
- Bit counter saturates at 2N+1.
- States: UNCFG, SHIFT, RUN, ERR.
- Reset (RN=0, async) clears:
  - state -> UNCFG
  - counter, shift register, active config, all cell registers q -> 0
  - CFG_DONE=0, CFG_ERR=0
- RN has priority over every other input.
- Entering SHIFT: from UNCFG, RUN or ERR, CFG_EN=1 at an edge moves to SHIFT and shifts in that edge's CFG_D (counter=1). CFG_ERR clears on that edge.
- In SHIFT with CFG_EN=1: shift CFG_D, counter++ (saturating).
- Leaving SHIFT (CFG_EN=0 at an edge):
  - counter==2N: copy shift register to active config, counter=0, state RUN, CFG_DONE=1.
  - Otherwise: state ERR, CFG_ERR=1, CFG_DONE=0, active config cleared.
- During SHIFT entered from RUN:
  - Old active config stays in effect; CFG_DONE stays 1 and outputs keep operating.
  - New config takes effect combinationally from the commit edge.
- UNCFG/ERR: Y=0, YE=0, FB=0. Cell registers still capture A.
- RUN, registered cell:
  - q[i] <= A[i] each posedge.
  - Y[i] = INVERTED ? ~q[i] : q[i].
  - FB[i] = q[i].
  - Latency 1 edge.
- RUN, combinational cell:
  - Y[i] = INVERTED ? ~A[i] : A[i], zero latency.
  - FB[i] = Y[i].
- RUN: YE[i] = E[i].
- Cell registers clock in every state; switching a cell to registered exposes its current q at once.

Optional Feature:
- Macro GAL_OLMC_SYNC_PRESET_EN.
- Defined:
  - Adds input SP (1 bit).
  - SP=1 at a posedge forces q[i] <= 1 for all cells, overriding A. Combinational cells are unaffected.
  - RN low overrides SP.
- Undefined: SP port absent; registers follow A only.

Test Plan:
- Basic registered load, N=8: reset, shift cfg=16'h5555 (all registered, non-inverted), drop CFG_EN.
  - Expect CFG_DONE=1, CFG_ERR=0.
  - A=8'hA5, E=8'hFF -> after next edge Y=8'hA5, FB=8'hA5, YE=8'hFF.
- Combinational inverted: load cfg=16'hAAAA, A=8'h3C, E=8'h0F.
  - Expect Y=8'hC3 with no clock edge, YE=8'h0F, FB=8'hC3.
- Wrong length: load 15 bits -> CFG_ERR=1, CFG_DONE=0, Y=0, YE=0. Load 17 bits -> same. Next 16-bit load -> CFG_DONE=1, CFG_ERR=0.
- Reset mid-shift: RN low after 7 bits -> all outputs 0, state UNCFG. Following full 16-bit load succeeds.
- Reconfigure in RUN: 16'h5555 active, A toggling.
  - During 16-bit shift of 16'hFFFF, Y keeps following old config with 1-edge latency and CFG_DONE stays 1.
  - From the commit edge, Y = ~q.
- GAL_OLMC_SYNC_PRESET_EN build, cfg=16'h5555 except cell 0 inverted:
  - SP=1, A=0 -> Y=8'hFE after the edge.
  - RN low with SP=1 -> Y=8'h00, CFG_DONE=0.
